// File: rtl/reg_bus_master_pkg.sv
// Shared types and constants for register-bus agents.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bus_master_pkg;

    // Master FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } reg_bus_state_e;

    // Widest register data any agent is expected to carry.
    localparam int REG_BUS_MAX_W = 64;

    // Read data returned on writes and on error responses.
    localparam logic [REG_BUS_MAX_W-1:0] REG_BUS_RDATA_ERR = '0;

endpackage

// File: rtl/reg_bus_timer.sv
// Clear/enable cycle counter; expired is high when TIMEOUT_P-1 enabled cycles have elapsed since clear.
// Latency: expired decodes the count register directly (no extra cycle).
// Backpressure: none; the owner stops enabling once expired is acted upon.
//
// Ports:
//   clk, reset_L : clock, synchronous active-low reset
//   clear        : force count to zero (wins over en)
//   en           : advance the count by one
//   expired      : count has reached TIMEOUT_P-1
module reg_bus_timer #(
    parameter int TIMEOUT_P = 8
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_P > 2) ? $clog2(TIMEOUT_P) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_P - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST_CNT);

endmodule

// File: rtl/reg_bus_master.sv
// Host-to-register-bus master: one transaction at a time, single-cycle req, one-cycle response.
// Latency: accept N -> req N+1 -> ack N+2 -> resp N+3; timeout resp N+2+TIMEOUT_P; undecoded resp N+1.
// Backpressure: host_ready low from accept until the cycle after the response; no response backpressure.
//
// Ports:
//   clk, reset_L                    : clock, synchronous active-low reset
//   host_valid/host_ready           : host handshake
//   host_rd_wr/host_addr/host_wdata : host transaction (1 = read)
//   resp_valid/resp_rdata/resp_err  : one-cycle host response
//   req/rd_wr/addr/write_val        : shared register bus towards the per-register blocks
//   ack_vec/read_val_bus            : per-slot ack and read data, slot i at [i*REG_SIZE_P +: REG_SIZE_P]
//   timeout_cnt                     : saturating error-response count, only with REG_BUS_MASTER_STATS_EN
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int REG_SIZE_P  = 32,
    parameter int ADDR_SIZE_P = 4,
    parameter int NUM_REGS_P  = 4,
    parameter int TIMEOUT_P   = 8
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           host_valid,
    output logic                           host_ready,
    input  logic                           host_rd_wr,
    input  logic [ADDR_SIZE_P-1:0]         host_addr,
    input  logic [REG_SIZE_P-1:0]          host_wdata,
    output logic                           resp_valid,
    output logic [REG_SIZE_P-1:0]          resp_rdata,
    output logic                           resp_err,
    output logic                           req,
    output logic                           rd_wr,
    output logic [ADDR_SIZE_P-1:0]         addr,
    output logic [REG_SIZE_P-1:0]          write_val,
    input  logic [NUM_REGS_P-1:0]          ack_vec,
    input  logic [NUM_REGS_P*REG_SIZE_P-1:0] read_val_bus
`ifdef REG_BUS_MASTER_STATS_EN
    ,
    output logic [15:0]                    timeout_cnt
`endif
);

    localparam logic [ADDR_SIZE_P:0]  NUM_REGS_L = (ADDR_SIZE_P + 1)'(NUM_REGS_P);
    localparam logic [REG_SIZE_P-1:0] RDATA_ERR  = REG_BUS_RDATA_ERR[REG_SIZE_P-1:0];

    reg_bus_state_e        state;
    logic                  host_fire;
    logic                  host_decoded;
    logic                  ack_sel;
    logic [REG_SIZE_P-1:0] rdata_sel;
    logic                  timer_clear;
    logic                  timer_en;
    logic                  timer_expired;

    assign host_fire    = (state == IDLE) && host_valid && host_ready;
    // Extra MSB keeps the compare correct when NUM_REGS_P == 2**ADDR_SIZE_P.
    assign host_decoded = ({1'b0, host_addr} < NUM_REGS_L);

    // Only the addressed slot is looked at; acks from other slots are dropped here.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_REGS_P; i++) begin
            if (addr == ADDR_SIZE_P'(i)) begin
                ack_sel   = ack_vec[i];
                rdata_sel = read_val_bus[i*REG_SIZE_P +: REG_SIZE_P];
            end
        end
    end

    // Counter is zeroed during REQ so the first WAIT cycle sees count 0.
    assign timer_clear = (state == REQ);
    assign timer_en    = (state == WAIT) && !ack_sel;

    reg_bus_timer #(
        .TIMEOUT_P (TIMEOUT_P)
    ) u_timer (
        .clk     (clk),
        .reset_L (reset_L),
        .clear   (timer_clear),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state      <= IDLE;
            host_ready <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req        <= 1'b0;
            rd_wr      <= 1'b0;
            addr       <= '0;
            write_val  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    host_ready <= 1'b1;
                    resp_valid <= 1'b0;
                    if (host_fire) begin
                        host_ready <= 1'b0;
                        rd_wr      <= host_rd_wr;
                        addr       <= host_addr;
                        write_val  <= host_wdata;
                        if (host_decoded) begin
                            req   <= 1'b1;
                            state <= REQ;
                        end else begin
                            // Undecoded: skip the bus entirely and answer next cycle.
                            resp_valid <= 1'b1;
                            resp_rdata <= RDATA_ERR;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                REQ: begin
                    req   <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (ack_sel) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= rd_wr ? rdata_sel : RDATA_ERR;
                        resp_err   <= 1'b0;
                        state      <= RESP;
                    end else if (timer_expired) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= RDATA_ERR;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    host_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef REG_BUS_MASTER_STATS_EN
    logic err_event;

    assign err_event = (host_fire && !host_decoded) ||
                       ((state == WAIT) && !ack_sel && timer_expired);

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            timeout_cnt <= '0;
        end else if (err_event && (timeout_cnt != 16'hFFFF)) begin
            timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
module tb_reg_bus_master;

    localparam int RS = 32;
    localparam int AS = 4;
    localparam int NR = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset_L;
    logic             host_valid;
    logic             host_ready;
    logic             host_rd_wr;
    logic [AS-1:0]    host_addr;
    logic [RS-1:0]    host_wdata;
    logic             resp_valid;
    logic [RS-1:0]    resp_rdata;
    logic             resp_err;
    logic             req;
    logic             rd_wr;
    logic [AS-1:0]    addr;
    logic [RS-1:0]    write_val;
    logic [NR-1:0]    ack_vec;
    logic [NR*RS-1:0] read_val_bus;
`ifdef REG_BUS_MASTER_STATS_EN
    logic [15:0]      timeout_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int err_cnt_model = 0;
    logic [RS-1:0] slot_val [NR];

    always #5 clk = ~clk;

    reg_bus_master #(
        .REG_SIZE_P  (RS),
        .ADDR_SIZE_P (AS),
        .NUM_REGS_P  (NR),
        .TIMEOUT_P   (TO)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_rd_wr   (host_rd_wr),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .req          (req),
        .rd_wr        (rd_wr),
        .addr         (addr),
        .write_val    (write_val),
        .ack_vec      (ack_vec),
        .read_val_bus (read_val_bus)
`ifdef REG_BUS_MASTER_STATS_EN
        ,
        .timeout_cnt  (timeout_cnt)
`endif
    );

    task automatic load_slots();
        for (int i = 0; i < NR; i++) read_val_bus[i*RS +: RS] = slot_val[i];
    endtask

    task automatic test_reset();
        reset_L = 1'b0; host_valid = 1'b0; host_rd_wr = 1'b0; host_addr = '0;
        host_wdata = '0; ack_vec = '0;
        for (int i = 0; i < NR; i++) slot_val[i] = '0;
        load_slots();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({host_ready, resp_valid, resp_rdata, resp_err, req, rd_wr, addr, write_val} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b rd=%h err=%b req=%b rw=%b a=%h wv=%h want all 0",
                     host_ready, resp_valid, resp_rdata, resp_err, req, rd_wr, addr, write_val);
        end
`ifdef REG_BUS_MASTER_STATS_EN
        checks++;
        if (timeout_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d want 0", timeout_cnt);
        end
`endif
        err_cnt_model = 0;
        reset_L = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", host_ready);
        end
    endtask

    // One transaction starting from an IDLE cycle (#1 after an edge, host_ready expected 1).
    // ack_d: cycles after req at which the addressed slot acks (0 = never).
    task automatic run_txn(input logic rd, input logic [AS-1:0] a, input logic [RS-1:0] wd,
                           input int ack_d, input bit noise, input bit keep_valid, input string name);
        bit            dec;
        bit            acked;
        int            resp_off;
        logic          exp_err;
        logic [RS-1:0] exp_rdata;
        logic [NR-1:0] nz;

        dec       = (int'(a) < NR);
        acked     = dec && (ack_d >= 1) && (ack_d <= TO);
        resp_off  = !dec ? 1 : (acked ? 2 + ack_d : 2 + TO);
        exp_err   = !acked;
        exp_rdata = (acked && rd) ? slot_val[a] : '0;
        if (exp_err) err_cnt_model++;
        load_slots();

        checks++;
        if (host_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, host_ready);
        end
        host_valid = 1'b1; host_rd_wr = rd; host_addr = a; host_wdata = wd; ack_vec = '0;

        for (int off = 1; off <= resp_off + 1; off++) begin
            @(posedge clk); #1;
            if (keep_valid && off <= resp_off) begin
                host_valid = 1'b1; host_rd_wr = 1'($urandom);
                host_addr = AS'($urandom); host_wdata = $urandom;
            end else begin
                host_valid = 1'b0;
            end

            checks++;
            if (req !== (dec && off == 1)) begin
                errors++;
                $display("FAIL %s req@%0d: got %b want %b", name, off, req, (dec && off == 1));
            end
            checks++;
            if ({rd_wr, addr, write_val} !== {rd, a, wd}) begin
                errors++;
                $display("FAIL %s bus@%0d: got rw=%b a=%h wv=%h want rw=%b a=%h wv=%h",
                         name, off, rd_wr, addr, write_val, rd, a, wd);
            end
            checks++;
            if (resp_valid !== (off == resp_off)) begin
                errors++;
                $display("FAIL %s resp_valid@%0d: got %b want %b", name, off, resp_valid, (off == resp_off));
            end
            if (off == resp_off) begin
                checks++;
                if ({resp_err, resp_rdata} !== {exp_err, exp_rdata}) begin
                    errors++;
                    $display("FAIL %s resp: got err=%b rdata=%h want err=%b rdata=%h",
                             name, resp_err, resp_rdata, exp_err, exp_rdata);
                end
`ifdef REG_BUS_MASTER_STATS_EN
                checks++;
                if (timeout_cnt !== 16'(err_cnt_model)) begin
                    errors++;
                    $display("FAIL %s stats: got %0d want %0d", name, timeout_cnt, err_cnt_model);
                end
`endif
            end
            checks++;
            if (host_ready !== (off == resp_off + 1)) begin
                errors++;
                $display("FAIL %s host_ready@%0d: got %b want %b", name, off, host_ready, (off == resp_off + 1));
            end

            // Acks for the cycle that follows this sample.
            nz = noise ? NR'($urandom) : '0;
            if (dec) nz = nz & ~(NR'(1) << a);
            if (dec && ack_d > 0 && off == 1 + ack_d && off <= resp_off) nz = nz | (NR'(1) << a);
            ack_vec = (off <= resp_off) ? nz : '0;
        end
        ack_vec = '0;
    endtask

    task automatic test_directed();
        slot_val[0] = 32'h1111_0000; slot_val[1] = 32'h0000_00A1;
        slot_val[2] = 32'h2222_2222; slot_val[3] = 32'h3333_3333;
        run_txn(1'b1, 4'd1, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, "read_a1");
        run_txn(1'b0, 4'd0, 32'h0000_0031, 1, 1'b0, 1'b0, "write_a0");
        run_txn(1'b1, 4'd2, 32'h0,         0, 1'b0, 1'b1, "timeout_a2");
        run_txn(1'b1, 4'd9, 32'h5,         0, 1'b0, 1'b0, "undecoded_a9");
        run_txn(1'b1, 4'd1, 32'h0,        TO, 1'b1, 1'b0, "ack_at_last_wait");
        run_txn(1'b1, 4'd3, 32'h0,    TO + 1, 1'b1, 1'b0, "ack_too_late");
        run_txn(1'b1, 4'd15, 32'h7,        1, 1'b1, 1'b1, "undecoded_a15");
    endtask

    task automatic test_random();
        int d;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) slot_val[i] = $urandom;
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = TO;
                2:       d = TO + 2;
                default: d = $urandom_range(1, 3);
            endcase
            run_txn(1'($urandom), AS'($urandom_range(0, 5)), $urandom, d,
                    1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            slot_val[n] = $urandom;
            run_txn(1'b1, AS'(n), $urandom, 1, 1'b0, 1'b0, "b2b");
        end
    endtask

    task automatic test_reset_mid();
        slot_val[2] = 32'hCAFE_0002;
        load_slots();
        host_valid = 1'b1; host_rd_wr = 1'b1; host_addr = 4'd2; host_wdata = '0; ack_vec = '0;
        @(posedge clk); #1;                 // REQ
        host_valid = 1'b0;
        @(posedge clk); #1;                 // WAIT
        reset_L = 1'b0;
        @(posedge clk); #1;                 // reset sampled
        checks++;
        if ({host_ready, resp_valid, resp_rdata, resp_err, req, rd_wr, addr, write_val} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdy=%b rv=%b rd=%h err=%b req=%b rw=%b a=%h wv=%h want all 0",
                     host_ready, resp_valid, resp_rdata, resp_err, req, rd_wr, addr, write_val);
        end
        err_cnt_model = 0;
        reset_L = 1'b1;
        ack_vec = NR'(1) << 2;              // late ack
        @(posedge clk); #1;
        ack_vec = '0;
        checks++;
        if ({host_ready, resp_valid, req} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_late_ack: got rdy=%b rv=%b req=%b want 1 0 0", host_ready, resp_valid, req);
        end
        @(posedge clk); #1;
        checks++;
        if ({host_ready, resp_valid, req} !== 3'b100) begin
            errors++;
            $display("FAIL mid_reset_idle: got rdy=%b rv=%b req=%b want 1 0 0", host_ready, resp_valid, req);
        end
        run_txn(1'b1, 4'd7, 32'h0, 0, 1'b0, 1'b0, "after_reset_undecoded");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if something wedges the sequence above.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
